// File: rtl/product_accumulator_pkg.sv
// Shared types and width helpers for the product accumulator slice.
package product_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_GUARD_BITS = 8;
   localparam int PROD_WIDTH     = 2 * DEF_DATA_WIDTH;
   localparam int ACC_WIDTH      = PROD_WIDTH + DEF_GUARD_BITS;

   function automatic int prod_width(input int data_width);
      return 2 * data_width;
   endfunction

   function automatic int acc_width(input int data_width, input int guard_bits);
      return prod_width(data_width) + guard_bits;
   endfunction

endpackage

// File: rtl/product_accumulator_acc_adder.sv
// Accumulator adder with carry-out; ACC_SATURATE_EN clamps a carrying sum to all-ones,
// otherwise the sum wraps.
module acc_adder
   import product_accumulator_pkg::*;
#(
   parameter int ACC_W  = ACC_WIDTH,
   parameter int PROD_W = PROD_WIDTH
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] product,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   logic [ACC_W:0] raw;

   assign raw   = {1'b0, acc} + (ACC_W + 1)'(product);
   assign carry = raw[ACC_W];

`ifdef ACC_SATURATE_EN
   assign sum = carry ? '1 : raw[ACC_W-1:0];
`else
   assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmable number of unsigned products and hands the result to the reader
// with a valid/ack handshake. Saturating adds are built with ACC_SATURATE_EN.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int GUARD_BITS = DEF_GUARD_BITS,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     clear,
   input  logic [CNT_WIDTH-1:0]                     num_terms,
   input  logic [prod_width(DATA_WIDTH)-1:0]        in_product,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   output logic [acc_width(DATA_WIDTH,GUARD_BITS)-1:0] out_sum,
   output logic                                     out_valid,
   input  logic                                     out_ack,
   output logic                                     busy,
   output logic                                     drop_err,
   output logic                                     overflow
);

   localparam int PW = prod_width(DATA_WIDTH);
   localparam int AW = acc_width(DATA_WIDTH, GUARD_BITS);

   state_t               state, state_nxt;
   logic [AW-1:0]        acc, acc_nxt, add_sum;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt, terms, terms_nxt, cnt_inc, eff_terms;
   logic                 drop_nxt, ovf_nxt, add_carry, start;

   acc_adder #(.ACC_W(AW), .PROD_W(PW)) u_acc_adder (
      .acc    (acc),
      .product(in_product),
      .sum    (add_sum),
      .carry  (add_carry)
   );

   // Ack frees the slot in the same cycle so a new first term can enter back-to-back.
   assign in_ready  = (state != HOLD) | out_ack;
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);
   assign out_sum   = acc;
   assign cnt_inc   = cnt + CNT_WIDTH'(1);
   assign eff_terms = (num_terms == '0) ? CNT_WIDTH'(1) : num_terms;

   always_comb begin
      // NOTE: every value produced here gets a default first, so no latch is inferred.
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      terms_nxt = terms;
      drop_nxt  = drop_err | (in_valid & ~in_ready);
      ovf_nxt   = overflow;
      start     = 1'b0;

      unique case (state)
         IDLE:  start = in_valid;
         ACCUM: begin
            if (in_valid) begin
               acc_nxt = add_sum;
               cnt_nxt = cnt_inc;
               ovf_nxt = overflow | add_carry;
               if (cnt_inc == terms) state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ack) begin
               state_nxt = IDLE;
               start     = in_valid;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (start) begin
         acc_nxt   = AW'(in_product);
         cnt_nxt   = CNT_WIDTH'(1);
         terms_nxt = eff_terms;
         state_nxt = (eff_terms == CNT_WIDTH'(1)) ? HOLD : ACCUM;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset || clear) begin
         state    <= IDLE;
         acc      <= '0;
         cnt      <= '0;
         terms    <= '0;
         drop_err <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         cnt      <= cnt_nxt;
         terms    <= terms_nxt;
         drop_err <= drop_nxt;
         overflow <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: a default instance and a zero-guard-bit instance share all inputs,
// and both are compared against an arbitrary-precision sum model.
module tb_product_accumulator;

   localparam int CW  = 8;
   localparam int PW  = 64;
   localparam int AW  = 72;
   localparam int AW0 = 64;

   logic          clk = 1'b0;
   logic          reset, clear, in_valid, out_ack;
   logic [CW-1:0] num_terms;
   logic [PW-1:0] in_product;

   logic          in_ready, out_valid, busy, drop_err, overflow;
   logic [AW-1:0] out_sum;
   logic          ng_in_ready, ng_out_valid, ng_busy, ng_drop_err, ng_overflow;
   logic [AW0-1:0] ng_out_sum;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   product_accumulator #(.DATA_WIDTH(32), .GUARD_BITS(8), .CNT_WIDTH(CW)) u_dut (
      .clk(clk), .reset(reset), .clear(clear), .num_terms(num_terms),
      .in_product(in_product), .in_valid(in_valid), .in_ready(in_ready),
      .out_sum(out_sum), .out_valid(out_valid), .out_ack(out_ack),
      .busy(busy), .drop_err(drop_err), .overflow(overflow)
   );

   product_accumulator #(.DATA_WIDTH(32), .GUARD_BITS(0), .CNT_WIDTH(CW)) u_dut_ng (
      .clk(clk), .reset(reset), .clear(clear), .num_terms(num_terms),
      .in_product(in_product), .in_valid(in_valid), .in_ready(ng_in_ready),
      .out_sum(ng_out_sum), .out_valid(ng_out_valid), .out_ack(out_ack),
      .busy(ng_busy), .drop_err(ng_drop_err), .overflow(ng_overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model of the zero-guard instance: wrap modulo 2**64, or clamp when saturating.
   function automatic logic [AW0-1:0] ng_expect(input logic [79:0] true_sum);
`ifdef ACC_SATURATE_EN
      return (true_sum > 80'hFFFF_FFFF_FFFF_FFFF) ? '1 : true_sum[AW0-1:0];
`else
      return true_sum[AW0-1:0];
`endif
   endfunction

   task automatic do_clear();
      clear = 1'b1; in_valid = 1'b0; out_ack = 1'b0;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
      num_terms = '0; in_product = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, busy, drop_err, overflow, in_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00001", {out_valid, busy, drop_err, overflow, in_ready});
      end
      n_tests++;
      if (out_sum !== '0) begin
         n_fail++; $display("FAIL reset_sum: got %h want 0", out_sum);
      end
   endtask

   task automatic test_four_terms();
      logic [PW-1:0] vals [4] = '{64'd3, 64'd5, 64'd7, 64'd9};
      num_terms = 8'd4;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_product = vals[i];
         tick();
         n_tests++;
         if (busy !== 1'b1 || out_valid !== (i == 3)) begin
            n_fail++;
            $display("FAIL four_terms_step%0d: busy=%b out_valid=%b want busy=1 out_valid=%b", i, busy, out_valid, i == 3);
         end
      end
      in_valid = 1'b0;
      n_tests++;
      if (out_sum !== 72'd24) begin
         n_fail++; $display("FAIL four_terms_sum: got %0d want 24", out_sum);
      end
      n_tests++;
      if (drop_err !== 1'b0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL four_terms_flags: drop_err=%b overflow=%b want 0 0", drop_err, overflow);
      end
      out_ack = 1'b1; tick(); out_ack = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL four_terms_ack: out_valid=%b busy=%b want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_zero_terms();
      num_terms = 8'd0; in_valid = 1'b1; in_product = 64'hFFFF_FFFE_0000_0001;
      tick();
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || out_sum !== 72'h00_FFFF_FFFE_0000_0001) begin
         n_fail++; $display("FAIL zero_terms: out_valid=%b sum=%h want 1 00fffffffe00000001", out_valid, out_sum);
      end
      out_ack = 1'b1; tick(); out_ack = 1'b0;
   endtask

   task automatic test_drop_and_back_to_back();
      num_terms = 8'd1; in_valid = 1'b1; in_product = 64'd11;
      tick();
      in_product = 64'd99; out_ack = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL hold_ready: got %b want 0", in_ready);
      end
      tick();
      n_tests++;
      if (drop_err !== 1'b1 || out_valid !== 1'b1 || out_sum !== 72'd11) begin
         n_fail++; $display("FAIL drop: drop_err=%b out_valid=%b sum=%0d want 1 1 11", drop_err, out_valid, out_sum);
      end
      in_product = 64'd2; out_ack = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL ack_ready: got %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0; out_ack = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || out_sum !== 72'd2 || drop_err !== 1'b1) begin
         n_fail++; $display("FAIL back_to_back: out_valid=%b sum=%0d drop_err=%b want 1 2 1", out_valid, out_sum, drop_err);
      end
      out_ack = 1'b1; tick(); out_ack = 1'b0;
      do_clear();
      n_tests++;
      if (drop_err !== 1'b0) begin
         n_fail++; $display("FAIL drop_clear: got %b want 0", drop_err);
      end
   endtask

   task automatic test_clear_and_reset();
      num_terms = 8'd3;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_product = 64'd100 + 64'(i);
         tick();
      end
      clear = 1'b1; in_product = 64'd7;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || out_sum !== '0) begin
         n_fail++; $display("FAIL clear_abort: busy=%b sum=%0d want 0 0", busy, out_sum);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_no_valid%0d: got %b want 0", i, out_valid);
         end
      end
      num_terms = 8'd1; in_valid = 1'b1; in_product = 64'd5;
      tick();
      in_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_hold: out_valid=%b busy=%b want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_gaps();
      logic [PW-1:0] vals [3] = '{64'd10, 64'd20, 64'd30};
      num_terms = 8'd3;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_product = vals[i];
         tick();
         in_valid = 1'b0;
         n_tests++;
         if (out_valid !== (i == 2)) begin
            n_fail++; $display("FAIL gaps_valid%0d: got %b want %b", i, out_valid, i == 2);
         end
         if (i < 2) tick();
      end
      n_tests++;
      if (out_sum !== 72'd60) begin
         n_fail++; $display("FAIL gaps_sum: got %0d want 60", out_sum);
      end
      out_ack = 1'b1; tick(); out_ack = 1'b0;
   endtask

   task automatic test_overflow();
      logic [79:0] true_sum;
      do_clear();
      num_terms = 8'd2; true_sum = '0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_product = '1;
         true_sum += 80'(64'hFFFF_FFFF_FFFF_FFFF);
         tick();
      end
      in_valid = 1'b0;
      n_tests++;
      if (ng_overflow !== 1'b1 || ng_out_sum !== ng_expect(true_sum)) begin
         n_fail++; $display("FAIL ovf_ng: overflow=%b sum=%h want 1 %h", ng_overflow, ng_out_sum, ng_expect(true_sum));
      end
      n_tests++;
      if (overflow !== 1'b0 || out_sum !== true_sum[AW-1:0]) begin
         n_fail++; $display("FAIL ovf_guarded: overflow=%b sum=%h want 0 %h", overflow, out_sum, true_sum[AW-1:0]);
      end
      out_ack = 1'b1; tick(); out_ack = 1'b0;
      do_clear();
   endtask

   task automatic test_random();
      logic [79:0]   true_sum;
      logic [PW-1:0] p;
      logic          hold_pending = 1'b0;
      logic          exp_ovf_ng   = 1'b0;
      int            nt, eff;
      for (int r = 0; r < 30; r++) begin
         nt  = $urandom_range(0, 5);
         eff = (nt == 0) ? 1 : nt;
         true_sum  = '0;
         num_terms = CW'(nt);
         for (int i = 0; i < eff; i++) begin
            if (i > 0) begin
               repeat ($urandom_range(0, 2)) begin
                  in_valid = 1'b0; tick();
               end
            end
            p = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) p = '1;
            in_valid = 1'b1; in_product = p;
            out_ack = (i == 0) && hold_pending;
            tick();
            in_valid = 1'b0; out_ack = 1'b0;
            num_terms = CW'($urandom);
            true_sum += 80'(p);
            n_tests++;
            if (out_valid !== (i == eff - 1) || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL rand%0d_step%0d: out_valid=%b busy=%b want %b 1", r, i, out_valid, busy, i == eff - 1);
            end
         end
         if (true_sum > 80'hFFFF_FFFF_FFFF_FFFF) exp_ovf_ng = 1'b1;
         n_tests++;
         if (out_sum !== true_sum[AW-1:0] || overflow !== 1'b0) begin
            n_fail++; $display("FAIL rand%0d_sum: sum=%h ovf=%b want %h 0", r, out_sum, overflow, true_sum[AW-1:0]);
         end
         n_tests++;
         if (ng_out_sum !== ng_expect(true_sum) || ng_overflow !== exp_ovf_ng) begin
            n_fail++;
            $display("FAIL rand%0d_ng: sum=%h ovf=%b want %h %b", r, ng_out_sum, ng_overflow, ng_expect(true_sum), exp_ovf_ng);
         end
         hold_pending = ($urandom_range(0, 1) == 1);
         if (!hold_pending) begin
            out_ack = 1'b1; tick(); out_ack = 1'b0;
            n_tests++;
            if (out_valid !== 1'b0) begin
               n_fail++; $display("FAIL rand%0d_ack: out_valid=%b want 0", r, out_valid);
            end
         end
      end
      if (hold_pending) begin
         out_ack = 1'b1; tick(); out_ack = 1'b0;
      end
      n_tests++;
      if (drop_err !== 1'b0) begin
         n_fail++; $display("FAIL rand_drop: got %b want 0", drop_err);
      end
   endtask

   initial begin
      test_reset();
      test_four_terms();
      test_zero_terms();
      test_drop_and_back_to_back();
      test_clear_and_reset();
      test_gaps();
      test_overflow();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the multiplier.
- Consumes the multiplier's registered product stream (product + ready) and sums a programmable number of consecutive products into one wide result (dot-product / MAC reduction).
- Presents that result to the PS-side reader with a valid/ack handshake.
- Unsigned arithmetic throughout, matching the multiplier.

Parameters:
DATA_WIDTH, 32, multiplier operand width; incoming product is 2*DATA_WIDTH bits
GUARD_BITS, 8, extra accumulator MSBs above product width
CNT_WIDTH, 8, width of term count; max terms per result = 2**CNT_WIDTH-1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
clear  input  1  synchronous abort: return to IDLE, zero accumulator, clear flags
num_terms  input  CNT_WIDTH  products per result; sampled on first accepted term; 0 treated as 1
in_product  input  2*DATA_WIDTH  product from multiplier
in_valid  input  1  product valid (multiplier ready)
in_ready  output  1  term accepted this cycle when in_valid & in_ready
out_sum  output  2*DATA_WIDTH+GUARD_BITS  accumulated result
out_valid  output  1  result available
out_ack  input  1  reader consumes result
busy  output  1  high in ACCUM or HOLD
drop_err  output  1  sticky: in_valid seen while in_ready low
overflow  output  1  sticky: accumulator carry-out / saturation occurred

Behaviour:
- Clock/reset: clk; reset is synchronous, active-high.
- Reset and clear: state=IDLE, acc=0, cnt=0, terms=0, out_valid=0, busy=0, drop_err=0, overflow=0. in_ready is high after reset.
- Precedence: reset > clear > all other events, including mid-accumulation and mid-HOLD. Any partial sum is discarded.
- State IDLE, on in_valid:
  - acc <= zero-extended in_product; cnt <= 1; terms <= max(num_terms,1).
  - If terms==1, go to HOLD; else go to ACCUM.
- State ACCUM, on in_valid:
  - acc <= acc + in_product; cnt <= cnt+1.
  - When cnt+1==terms, go to HOLD.
  - Cycles without in_valid hold state (gaps allowed).
- State HOLD:
  - out_valid=1, out_sum=acc, stable until out_ack.
  - On out_ack, go to IDLE.
  - If in_valid is also high that cycle, it is accepted as the first term of the next result (same action as IDLE).
- in_ready = (state!=HOLD) | out_ack. This is a combinational path from out_ack.
- Latency: out_valid rises the cycle after the final term is accepted. Single-term result: in_valid at cycle N gives out_valid at N+1.
- Throughput: one term per cycle. Back-to-back results are possible via same-cycle ack.
- drop_err: set when in_valid & !in_ready. The term is discarded. The multiplier has no stall, so this is the only indication. Cleared only by reset/clear.
- Width: acc is 2*DATA_WIDTH+GUARD_BITS wide. A carry-out of the MSB sets overflow.
- num_terms is ignored after the first term is latched.
- out_ack outside HOLD is ignored.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: an addition that would carry out clamps acc to all-ones. It stays at all-ones for the rest of that result, and overflow is set.
- Undefined: acc wraps modulo 2**(2*DATA_WIDTH+GUARD_BITS). overflow still flags the carry-out.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ACCUM, HOLD};
  - localparams PROD_WIDTH=2*DATA_WIDTH and ACC_WIDTH=PROD_WIDTH+GUARD_BITS;
  - a width helper function.
- One natural sub-module, acc_adder: combinational add with carry-out and optional saturation, under the ACC_SATURATE_EN guard.
- The FSM, counter and flags stay in the top module.

Test Plan:
- num_terms=4, DATA_WIDTH=32, products 3,5,7,9 on consecutive cycles -> out_valid one cycle after 4th term, out_sum=24, busy high throughout, no flags.
- num_terms=0, single product 0xFFFF_FFFE_0000_0001 -> treated as 1 term, out_sum=0x00_FFFF_FFFE_0000_0001 next cycle.
- HOLD with out_ack low, in_valid pulse -> in_ready=0, drop_err=1, out_sum unchanged. Then same-cycle out_ack+in_valid with product 2 (num_terms=1) -> new out_valid next cycle with out_sum=2.
- num_terms=3, two terms accepted, then clear -> IDLE, acc=0, out_valid never asserts. Reset mid-HOLD -> out_valid=0 next cycle.
- GUARD_BITS=0, num_terms=2, products all-ones ×2 -> overflow=1. With ACC_SATURATE_EN, out_sum=all-ones. Without it, out_sum=all-ones-1.
- num_terms=3 with one idle gap between each of 10,20,30 -> out_sum=60 one cycle after the 3rd term.
